// File: rtl/hack_pkg.sv
// ---------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the Hack CPU front end: machine word width, the
// address the program counter starts from, the fetch sequencer states and
// the {pc, data} entry carried by the fetch buffer.
// ---------------------------------------------------------------------------
package hack_pkg;

   localparam int                WORD_W       = 16;
   localparam logic [WORD_W-1:0] RESET_VECTOR = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no request to the ROM
      FETCH = 2'd1,   // request for pc outstanding, word will be kept
      FLUSH = 2'd2    // request outstanding from before a jump, word dropped
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry synchronous FIFO of {pc, data} fetch entries sitting between
// the ROM fetch sequencer and decode.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   push        write din at the tail this cycle
//   pop         drop the head this cycle
//   clear       empty the FIFO (wins over push and pop)
//   din         entry to write
//   count       number of valid entries
//   head        oldest entry (meaningful only while count != 0)
// ---------------------------------------------------------------------------
module fetch_fifo
   import hack_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  fetch_entry_t     din,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q;
   logic [PTR_W-1:0] wr_q;
   logic [CNT_W-1:0] cnt_q;

   // DEPTH is a power of two, so the pointers wrap on their own. When full,
   // a simultaneous push/pop writes the slot being popped at the same edge,
   // which is safe because the old head is consumed at that edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (clear) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= din;
            wr_q        <= wr_q + PTR_W'(1);
         end
         if (pop) rd_q <= rd_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign count = cnt_q;
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/inc16.sv
// ---------------------------------------------------------------------------
// inc16
// 16-bit incrementer, out = in + 1, wrapping 0xFFFF to 0x0000 silently.
// Ports:
//   in   16-bit operand
//   out  16-bit result
// ---------------------------------------------------------------------------
module inc16 (
   input  logic [15:0] in,
   output logic [15:0] out
);

   assign out = in + 16'd1;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Instruction-fetch controller for the Hack CPU. Owns the program counter,
// issues request/acknowledge reads to the instruction ROM, buffers fetched
// words and hands them to decode over valid/ready. A jump flushes the
// buffer, drops any in-flight word and redirects the PC.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   rom_req / rom_addr    ROM read request and its address (the pc register)
//   rom_ack / rom_data    ROM completion and instruction word
//   ins_valid/data/pc     buffer head towards decode
//   ins_ready             decode accepts the head
//   jump / jump_addr      one-cycle redirect and its target
//   halt                  suppresses new fetches (never aborts one in flight)
//   pc                    next address to fetch
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
   import hack_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              rom_req,
   output logic [WORD_W-1:0] rom_addr,
   input  logic              rom_ack,
   input  logic [WORD_W-1:0] rom_data,
   output logic              ins_valid,
   output logic [WORD_W-1:0] ins_data,
   output logic [WORD_W-1:0] ins_pc,
   input  logic              ins_ready,
   input  logic              jump,
   input  logic [WORD_W-1:0] jump_addr,
   input  logic              halt,
   output logic [WORD_W-1:0] pc
);

   localparam int               CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

   fetch_state_t      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d, pc_inc;
   logic              rom_req_q, rom_req_d;

   logic [CNT_W-1:0]  fifo_cnt;
   fetch_entry_t      fifo_head;
   fetch_entry_t      fifo_din;
   logic              pop, ack, push;
   logic [CNT_W:0]    cnt_after_pop, cnt_after_push;
   logic              space, room_after_push;

   inc16 u_inc16 (
      .in  (pc_q),
      .out (pc_inc)
   );

   assign pop  = ins_valid & ins_ready;
   assign ack  = rom_req_q & rom_ack;
   assign push = (state_q == FETCH) & ack & ~jump;

   // Occupancy is judged after this cycle's pop, so a full buffer that is
   // draining still counts as having room.
   assign cnt_after_pop   = {1'b0, fifo_cnt} - {{CNT_W{1'b0}}, pop};
   assign cnt_after_push  = cnt_after_pop + (CNT_W + 1)'(1);
   assign space           = cnt_after_pop < DEPTH_C;
   assign room_after_push = cnt_after_push < DEPTH_C;

   assign fifo_din = '{pc: pc_q, data: rom_data};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (jump),
      .din   (fifo_din),
      .count (fifo_cnt),
      .head  (fifo_head)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (jump) begin
         // A request left without its ack must still be drained from the ROM.
         pc_d    = jump_addr;
         state_d = ((state_q != IDLE) && !ack) ? FLUSH : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (space && !halt) state_d = FETCH;
            end
            FETCH: begin
               if (ack) begin
                  pc_d    = pc_inc;
                  state_d = (room_after_push && !halt) ? FETCH : IDLE;
               end
            end
            FLUSH: begin
               if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      rom_req_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_VECTOR;
         rom_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         rom_req_q <= rom_req_d;
      end
   end

   assign rom_req   = rom_req_q;
   assign rom_addr  = pc_q;
   assign pc        = pc_q;
   assign ins_valid = (fifo_cnt != '0);
   assign ins_data  = fifo_head.data;
   assign ins_pc    = fifo_head.pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed scenarios for the fetch controller followed by a randomized run
// against a program-order reference model: decode must see consecutive
// addresses starting from reset or from the latest jump target, each with
// the word the ROM returned for that address.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rom_req;
   logic [15:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;
   logic        ins_valid;
   logic [15:0] ins_data;
   logic [15:0] ins_pc;
   logic        ins_ready = 1'b0;
   logic        jump = 1'b0;
   logic [15:0] jump_addr = 16'h0000;
   logic        halt = 1'b0;
   logic [15:0] pc;

   logic        auto_ack = 1'b0;
   logic        man_ack = 1'b0;
   logic [15:0] man_data = 16'h0000;

   int n_chk = 0;
   int n_err = 0;

   // random-phase model state
   logic [15:0] exp_pc;
   logic [15:0] cur_addr;
   logic        jmp_prev, req_prev, ack_prev, halt_prev;
   logic [15:0] addr_prev;
   int          xfers;

   assign rom_ack  = auto_ack ? rom_req   : man_ack;
   assign rom_data = auto_ack ? ~rom_addr : man_data;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .rom_req   (rom_req),
      .rom_addr  (rom_addr),
      .rom_ack   (rom_ack),
      .rom_data  (rom_data),
      .ins_valid (ins_valid),
      .ins_data  (ins_data),
      .ins_pc    (ins_pc),
      .ins_ready (ins_ready),
      .jump      (jump),
      .jump_addr (jump_addr),
      .halt      (halt),
      .pc        (pc)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      jump      = 1'b0;
      halt      = 1'b0;
      ins_ready = 1'b0;
      auto_ack  = 1'b0;
      man_ack   = 1'b0;
      man_data  = 16'h0000;
      jump_addr = 16'h0000;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One cycle of the randomized run; rnd=0 gives an always-ready,
   // always-acking environment with no jump or halt.
   task automatic rnd_cycle(input bit rnd);
      logic [15:0] e;
      if (jmp_prev) check("rnd_jmp_vld", ins_valid, 0);
      if (req_prev && !ack_prev && !jmp_prev) begin
         check("rnd_req_hold", rom_req, 1);
         check("rnd_addr_hold", rom_addr, addr_prev);
      end
      if (halt_prev && (!req_prev || ack_prev)) check("rnd_halt_noreq", rom_req, 0);

      if (rnd) begin
         ins_ready = ($urandom_range(0, 3) != 0);
         halt      = ($urandom_range(0, 9) == 0);
         jump      = ($urandom_range(0, 19) == 0);
         jump_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                  : 16'($urandom);
      end else begin
         ins_ready = 1'b1;
         halt      = 1'b0;
         jump      = 1'b0;
      end

      // the ROM returns the word for the address at which the request began
      if (rom_req && (!req_prev || ack_prev)) cur_addr = rom_addr;
      man_ack  = rom_req && (!rnd || ($urandom_range(0, 2) != 0));
      man_data = ~cur_addr;

      if (ins_valid && ins_ready) begin
         e = ~exp_pc;
         check("rnd_ins_pc", ins_pc, exp_pc);
         check("rnd_ins_data", ins_data, e);
         exp_pc = exp_pc + 16'd1;
         xfers++;
      end
      if (jump) exp_pc = jump_addr;

      jmp_prev  = jump;
      req_prev  = rom_req;
      ack_prev  = man_ack;
      halt_prev = halt;
      addr_prev = rom_addr;
      tick();
   endtask

   initial begin
      logic [15:0] e;
      int          got;

      // ---- reset values and back-to-back fetch ----
      do_reset();
      check("rst_pc", pc, 16'h0000);
      check("rst_rom_addr", rom_addr, 16'h0000);
      check("rst_rom_req", rom_req, 0);
      check("rst_ins_valid", ins_valid, 0);
      check("rst_ins_data", ins_data, 16'h0000);
      check("rst_ins_pc", ins_pc, 16'h0000);
      ins_ready = 1'b1;
      auto_ack  = 1'b1;
      tick();
      check("first_req", rom_req, 1);
      check("first_addr", rom_addr, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         e = ~16'(i);
         check("seq_valid", ins_valid, 1);
         check("seq_pc", ins_pc, 16'(i));
         check("seq_data", ins_data, e);
         check("seq_pc_reg", pc, 16'(i + 1));
      end

      // ---- decode stalled: buffer fills, fetching stops, then resumes ----
      do_reset();
      auto_ack = 1'b1;
      tick();
      tick();
      tick();
      check("stall_req", rom_req, 0);
      check("stall_pc", pc, 16'h0002);
      check("stall_head", ins_pc, 16'h0000);
      tick();
      tick();
      check("stall_req_hold", rom_req, 0);
      check("stall_pc_hold", pc, 16'h0002);
      ins_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         if (ins_valid) begin
            e = ~16'(got);
            check("resume_pc", ins_pc, 16'(got));
            check("resume_data", ins_data, e);
            got++;
         end
         tick();
      end
      check("resume_count", got, 10);

      // ---- jump while a slow request is outstanding ----
      do_reset();
      ins_ready = 1'b1;
      jump_addr = 16'h0100;
      tick();
      check("slow_req", rom_req, 1);
      tick();
      jump = 1'b1;
      tick();
      jump = 1'b0;
      check("flush_req", rom_req, 1);
      check("flush_vld", ins_valid, 0);
      check("flush_pc", pc, 16'h0100);
      tick();
      man_ack  = 1'b1;
      man_data = 16'hDEAD;
      tick();
      man_ack = 1'b0;
      check("stale_req", rom_req, 0);
      check("stale_vld", ins_valid, 0);
      tick();
      check("redir_req", rom_req, 1);
      check("redir_addr", rom_addr, 16'h0100);
      auto_ack = 1'b1;
      tick();
      check("redir_vld", ins_valid, 1);
      check("redir_pc", ins_pc, 16'h0100);
      check("redir_data", ins_data, 16'hFEFF);

      // ---- jump coinciding with the ack for pc 5 ----
      do_reset();
      ins_ready = 1'b1;
      auto_ack  = 1'b1;
      repeat (6) tick();
      check("j5_pc", pc, 16'h0005);
      check("j5_head", ins_pc, 16'h0004);
      jump      = 1'b1;
      jump_addr = 16'h0040;
      tick();
      jump = 1'b0;
      check("j5_vld", ins_valid, 0);
      check("j5_req", rom_req, 0);
      check("j5_newpc", pc, 16'h0040);
      tick();
      check("j5_req2", rom_req, 1);
      check("j5_addr", rom_addr, 16'h0040);
      tick();
      check("j5_first_vld", ins_valid, 1);
      check("j5_first_pc", ins_pc, 16'h0040);

      // ---- pc wrap after a jump to 0xFFFE ----
      do_reset();
      ins_ready = 1'b1;
      auto_ack  = 1'b1;
      jump      = 1'b1;
      jump_addr = 16'hFFFE;
      tick();
      jump = 1'b0;
      check("wrap_pc", pc, 16'hFFFE);
      check("wrap_req0", rom_req, 0);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         e = 16'hFFFE + 16'(i);
         check("wrap_vld", ins_valid, 1);
         check("wrap_ins_pc", ins_pc, e);
         tick();
      end

      // ---- halt during an outstanding request, then async reset ----
      do_reset();
      ins_ready = 1'b1;
      tick();
      halt = 1'b1;
      tick();
      check("halt_keep_req", rom_req, 1);
      man_ack  = 1'b1;
      man_data = 16'hFFFF;
      tick();
      man_ack = 1'b0;
      check("halt_word_vld", ins_valid, 1);
      check("halt_word_pc", ins_pc, 16'h0000);
      check("halt_word_data", ins_data, 16'hFFFF);
      check("halt_req_off", rom_req, 0);
      repeat (4) begin
         tick();
         check("halt_noreq", rom_req, 0);
      end
      halt = 1'b0;
      tick();
      check("unhalt_req", rom_req, 1);
      check("unhalt_addr", rom_addr, 16'h0001);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_req", rom_req, 0);
      check("async_rst_pc", pc, 16'h0000);
      check("async_rst_vld", ins_valid, 0);
      tick();
      reset = 1'b0;

      // ---- randomized run against the program-order model ----
      do_reset();
      exp_pc    = 16'h0000;
      cur_addr  = 16'h0000;
      jmp_prev  = 1'b0;
      req_prev  = 1'b0;
      ack_prev  = 1'b0;
      halt_prev = 1'b0;
      addr_prev = 16'h0000;
      xfers     = 0;
      for (int i = 0; i < 3000; i++) rnd_cycle(1'b1);
      check("rnd_progress", (xfers > 500), 1);
      for (int i = 0; i < 6; i++) rnd_cycle(1'b0);
      xfers = 0;
      for (int i = 0; i < 8; i++) rnd_cycle(1'b0);
      check("drain_rate", xfers, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
